// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - request/response bus between the LSU and the data memory controller
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - RV32 byte-addressable data memory with wait states and one-shot response
// Optional misaligned-access error reporting is enabled by defining DMEM_MISALIGN_CHECK_EN.
module data_mem_ctrl #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_ctrl_if.slave  mem
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(DEPTH) << 2;
  localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [31:0]       mem_q [DEPTH];

  logic              accept;
  logic              enter_resp;
  logic              op_we;
  logic [2:0]        op_f3;
  logic [ADDR_W-1:0] op_addr;
  logic [31:0]       op_wdata;
  logic [IDX_W-1:0]  op_idx;
  logic [1:0]        off;
  logic [1:0]        eff_off;
  logic              sz_byte, sz_half, sz_word;
  logic              legal, oob, misalign, op_err;
  logic [3:0]        be;
  logic [31:0]       wsh;
  logic [31:0]       rd_word, rsh, ld;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem.req_valid) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP) && !rst;

  // With zero wait states the access completes on the accept edge, so the live request is used.
  assign op_we    = (state_q == S_IDLE) ? mem.req_we     : we_q;
  assign op_f3    = (state_q == S_IDLE) ? mem.req_funct3 : f3_q;
  assign op_addr  = (state_q == S_IDLE) ? mem.req_addr   : addr_q;
  assign op_wdata = (state_q == S_IDLE) ? mem.req_wdata  : wdata_q;

  assign op_idx  = op_addr[IDX_W+1:2];
  assign off     = op_addr[1:0];
  assign sz_byte = (op_f3[1:0] == 2'b00);
  assign sz_half = (op_f3[1:0] == 2'b01);
  assign sz_word = (op_f3[1:0] == 2'b10);
  assign eff_off = sz_byte ? off : (sz_half ? {off[1], 1'b0} : 2'b00);

  assign legal = op_we ? (op_f3 == 3'b000 || op_f3 == 3'b001 || op_f3 == 3'b010)
                       : (op_f3 != 3'b011 && op_f3 != 3'b110 && op_f3 != 3'b111);
  assign oob   = ({1'b0, op_addr} >= MEM_BYTES);
`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = (sz_half && off[0]) || (sz_word && (off != 2'b00));
`else
  assign misalign = 1'b0;
`endif
  assign op_err = !legal || oob || misalign;

  assign be  = sz_word ? 4'b1111 : (sz_half ? (4'b0011 << eff_off) : (4'b0001 << eff_off));
  assign wsh = op_wdata << {eff_off, 3'b000};

  assign rd_word = mem_q[op_idx];
  assign rsh     = rd_word >> {eff_off, 3'b000};

  always_comb begin
    ld = rsh;
    if (sz_byte)      ld = op_f3[2] ? {24'b0, rsh[7:0]}  : {{24{rsh[7]}}, rsh[7:0]};
    else if (sz_half) ld = op_f3[2] ? {16'b0, rsh[15:0]} : {{16{rsh[15]}}, rsh[15:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= mem.req_we;
        f3_q    <= mem.req_funct3;
        addr_q  <= mem.req_addr;
        wdata_q <= mem.req_wdata;
      end
      if (enter_resp) begin
        rdata_q <= (op_err || op_we) ? 32'd0 : ld;
        err_q   <= op_err;
      end
    end
  end

  // Storage is never reset; a store only lands on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (enter_resp && op_we && !op_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[op_idx][8*b +: 8] <= wsh[8*b +: 8];
      end
    end
  end

  assign mem.req_ready  = (state_q == S_IDLE);
  assign mem.resp_valid = (state_q == S_RESP);
  assign mem.resp_rdata = (state_q == S_RESP) ? rdata_q : 32'd0;
  assign mem.resp_err   = (state_q == S_RESP) ? err_q   : 1'b0;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl against a byte-array reference model
module tb_data_mem_ctrl;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 32;
  localparam int WS     = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] mb [DEPTH*4];

  data_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
    .clk (clk),
    .rst (rst),
    .mem (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: an access is `size` little-endian bytes starting at the size-aligned address.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic err, output logic [31:0] rd);
    int unsigned size;
    logic [31:0] a, v;
    bit legal;
    size  = 1 << f3[1:0];
    legal = we ? (f3 == 0 || f3 == 1 || f3 == 2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    err   = !legal || (addr >= DEPTH * 4);
`ifdef DMEM_MISALIGN_CHECK_EN
    if (legal && (addr % size) != 0) err = 1'b1;
`endif
    rd = 32'd0;
    if (!err) begin
      a = addr - (addr % size);
      if (we) begin
        for (int i = 0; i < int'(size); i++) mb[a + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < int'(size); i++) v = v | (32'(mb[a + i]) << (8 * i));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
        rd = v;
      end
    end
  endfunction

  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input bit hold, input string tag,
                      output logic [31:0] rd_o, output logic err_o);
    logic [31:0] rd_e;
    logic        err_e;
    bit          tok;
    int          n;
    tok = 1'b1;
    n   = 0;
    rd_o  = 32'hDEAD_BEEF;
    err_o = 1'bx;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) tok = 1'b0;
    @(posedge clk);
    if (!hold) begin
      #1;
      bus.req_valid = 1'b0;
      bus.req_wdata = $urandom;
    end
    for (int k = 1; k <= WS + 1; k++) begin
      @(negedge clk);
      if (bus.req_ready !== 1'b0) tok = 1'b0;
      if (bus.resp_valid !== (k == WS + 1)) tok = 1'b0;
      if (k == WS + 1) begin
        rd_o  = bus.resp_rdata;
        err_o = bus.resp_err;
        bus.req_valid = 1'b0;
      end else if (bus.resp_rdata !== 32'd0 || bus.resp_err !== 1'b0) begin
        tok = 1'b0;
      end
    end
    @(negedge clk);
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) tok = 1'b0;
    model(we, f3, addr, wd, err_e, rd_e);
    check({tag, "_timing"}, 32'(tok), 32'd1);
    check({tag, "_err"}, 32'(err_o), 32'(err_e));
    check({tag, "_rdata"}, rd_o, rd_e);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          seen;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_rdata", bus.resp_rdata, 32'd0);
    check("rst_err", 32'(bus.resp_err), 32'd0);
    rst = 1'b0;

    for (int w = 0; w < 16; w++) xact(1'b1, 3'b010, 32'(w * 4), $urandom, 1'b0, "fill", rd, er);

    // store aborted by reset while waiting
    xact(1'b1, 3'b010, 32'h30, 32'hCAFE_0001, 1'b0, "rst_pre", rd, er);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h30; bus.req_wdata = 32'h5555_AAAA;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0) seen++;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0) seen++;
    end
    check("rst_no_resp", 32'(seen), 32'd0);
    check("rst_ready_after", 32'(bus.req_ready), 32'd1);
    xact(1'b0, 3'b010, 32'h30, 32'd0, 1'b0, "rst_old", rd, er);
    check("rst_old_const", rd, 32'hCAFE_0001);

    xact(1'b1, 3'b010, 32'h10, 32'h8000_80FF, 1'b0, "t2_sw", rd, er);
    xact(1'b0, 3'b000, 32'h10, 32'd0, 1'b0, "t2_lb", rd, er);
    check("t2_lb_const", rd, 32'hFFFF_FFFF);
    xact(1'b0, 3'b100, 32'h10, 32'd0, 1'b1, "t2_lbu", rd, er);
    check("t2_lbu_const", rd, 32'h0000_00FF);
    xact(1'b0, 3'b001, 32'h12, 32'd0, 1'b0, "t2_lh", rd, er);
    check("t2_lh_const", rd, 32'hFFFF_8000);
    xact(1'b0, 3'b101, 32'h12, 32'd0, 1'b1, "t2_lhu", rd, er);
    check("t2_lhu_const", rd, 32'h0000_8000);

    xact(1'b1, 3'b010, 32'h20, 32'h1122_3344, 1'b0, "t3_sw", rd, er);
    xact(1'b1, 3'b000, 32'h21, 32'h0000_00AA, 1'b0, "t3_sb", rd, er);
    xact(1'b1, 3'b001, 32'h22, 32'h0000_BEEF, 1'b0, "t3_sh", rd, er);
    xact(1'b0, 3'b010, 32'h20, 32'd0, 1'b0, "t3_lw", rd, er);
    check("t3_lw_const", rd, 32'hBEEF_AA44);

    xact(1'b0, 3'b010, 32'h13, 32'd0, 1'b0, "t5_mis", rd, er);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("t5_err_const", 32'(er), 32'd1);
    check("t5_rd_const", rd, 32'd0);
`else
    check("t5_err_const", 32'(er), 32'd0);
    check("t5_rd_const", rd, 32'h8000_80FF);
`endif

    xact(1'b1, 3'b011, 32'h20, 32'h0BAD_0BAD, 1'b1, "t6_f3", rd, er);
    check("t6_f3_err_const", 32'(er), 32'd1);
    seen = 0;
    repeat (2 * WS + 4) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0) seen++;
    end
    check("t6_no_double", 32'(seen), 32'd0);
    xact(1'b1, 3'b100, 32'h20, 32'h0BAD_0BAD, 1'b1, "t6_sbu", rd, er);
    xact(1'b1, 3'b010, 32'(DEPTH * 4), 32'h0BAD_0BAD, 1'b0, "t6_oob_sw", rd, er);
    xact(1'b0, 3'b010, 32'(DEPTH * 4), 32'd0, 1'b0, "t6_oob_lw", rd, er);
    check("t6_oob_err_const", 32'(er), 32'd1);
    xact(1'b0, 3'b010, 32'h20, 32'd0, 1'b0, "t6_unchanged", rd, er);
    check("t6_unchanged_const", rd, 32'hBEEF_AA44);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] ad;
      ad = ($urandom_range(0, 9) == 0) ? 32'(DEPTH * 4 + $urandom_range(0, 100))
                                       : 32'($urandom_range(0, 63));
      xact(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ad, $urandom,
           1'($urandom_range(0, 1)), "rand", rd, er);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
